irq_ctl: RTL and testbench
==========================

IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 Parameter: RESET_MASK, default 8'h00, reset value of the enable mask (bit=1 enables source).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: src  input  8  interrupt source lines; src[0] is highest priority.
REQ-005 Port: iack  input  1  acknowledge level from the pipeline control FSM; rising edge = taken, falling edge = return.
REQ-006 Port: mask_we  input  1  mask write strobe.
REQ-007 Port: mask_wdata  input  8  new mask value.
REQ-008 Port: mask  output  8  current mask register.
REQ-009 Port: pend  output  8  pending register.
REQ-010 Port: irq  output  1  interrupt request to the pipeline control FSM.
REQ-011 Port: vec  output  3  index of the selected or in-service source.
REQ-012 Port: in_service  output  1  high while a taken interrupt is being serviced.

Function
REQ-013 The block SHALL register src once (src_q) and iack once (iack_q); all detection SHALL use these registered copies.
REQ-014 Pending update each cycle: pend[i] <= set[i] | (pend[i] & ~clr[i]). set and clr are defined by REQ-029/030; set wins if both occur in the same cycle.
REQ-015 When mask_we=1, mask SHALL take mask_wdata on the next edge. Masking a source SHALL NOT clear its pend bit.
REQ-016 eligible = pend & mask. Priority SHALL be fixed: lowest index wins.
REQ-017 FSM states: IDLE, REQ, SERV. All states are registered.
REQ-018 IDLE: if eligible!=0, go to REQ and latch vec = winning index; irq=0; in_service=0.
REQ-019 REQ: irq=1 and vec is held stable. If eligible[vec] drops to 0 (mask write or level deassert), return to IDLE; irq=0 from the next cycle.
REQ-020 REQ: on iack rising edge (iack & ~iack_q), go to SERV. In the same cycle, clr[vec]=1 (edge mode only).
REQ-021 If the conditions of REQ-019 and REQ-020 occur in the same cycle, REQ-020 SHALL take precedence.
REQ-022 SERV: irq=0, in_service=1, vec held. No new request SHALL be raised until an iack falling edge (~iack & iack_q), which moves the FSM to IDLE.
REQ-023 Minimum latency: eligible becomes 1 at edge N -> irq=1 after edge N+1.
REQ-024 A higher-priority source arriving during REQ or SERV SHALL NOT change vec. It SHALL be served on the next IDLE->REQ pass.
REQ-025 An iack rising edge seen in IDLE or SERV SHALL be ignored.

Reset
REQ-026 While rst=0 at a clock edge, the following SHALL be loaded: state=IDLE, pend=0, mask=RESET_MASK, vec=0, irq=0, in_service=0, src_q=0, iack_q=0.
REQ-027 Reset asserted during REQ or SERV SHALL abort immediately. Outputs SHALL equal their reset values from the cycle after the edge.
REQ-028 mask_we SHALL be ignored while rst=0.

Configuration
REQ-029 With IRQ_EDGE_EN defined: set[i] = src[i] & ~src_q[i] (rising edge of the raw line against its registered copy). pend is cleared only by REQ-020.
REQ-030 Without IRQ_EDGE_EN: level mode. set=src_q and clr=~src_q, so pend mirrors src_q, and REQ-020 performs no clear.

Verification
REQ-031 Edge mode, mask=8'hFF, pulse src[3] for 1 cycle -> pend=8'h08, irq=1 two cycles later with vec=3; raise iack -> irq=0, in_service=1, pend=0; drop iack -> IDLE.
REQ-032 Same cycle src[5] and src[2] rise -> vec=2. After the iack rise/fall cycle, a second request is raised with vec=5.
REQ-033 mask=8'h00, pulse src[1] -> pend=8'h02, irq stays 0. Then write mask=8'h02 -> irq=1 and vec=1 two cycles later.
REQ-034 In REQ with vec=4, write mask=8'hEF -> irq drops next cycle, state=IDLE, pend[4] remains 1.
REQ-035 Level mode: hold src[6]=1 through iack rise, SERV and iack fall -> irq=1 again with vec=6. Deassert src[6] while in REQ -> irq drops.
REQ-036 Assert rst=0 during SERV with pend=8'h81 -> next cycle: irq=0, in_service=0, pend=0, mask=RESET_MASK.

Source files
------------

// File: rtl/irq_ctl.sv
// irq_ctl: eight-source interrupt controller with a fixed-priority selector
// and an IDLE/REQ/SERV handshake toward the pipeline control FSM.
// src[0] has the highest priority.
//
// Build option:
//   IRQ_EDGE_EN  defined   -> edge mode. A rising src line sets its pend bit.
//                             The pend bit stays set until the request is taken.
//   IRQ_EDGE_EN  undefined -> level mode. pend follows the registered src lines.

module irq_ctl #(
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src,
  input  logic       iack,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic [7:0] mask,
  output logic [7:0] pend,
  output logic       irq,
  output logic [2:0] vec,
  output logic       in_service
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] src_q;
  logic       iack_q;

  logic [7:0] eligible;
  logic       iack_rise;
  logic       iack_fall;
  logic [2:0] win_idx;
  logic [7:0] set_v;
  logic [7:0] clr_v;
  logic [7:0] pend_next;

  // Enabled pending sources and acknowledge edges seen against the registered iack
  always_comb begin
    eligible  = pend & mask;
    iack_rise = iack & ~iack_q;
    iack_fall = ~iack & iack_q;
  end

  // Lowest-index eligible source wins, so scan from the top down
  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) win_idx = 3'(i);
    end
  end

`ifdef IRQ_EDGE_EN
  logic take;

  // Edge mode: a new rising edge sets pend; taking the request clears its bit
  always_comb begin
    take  = (state == REQ) && iack_rise;
    set_v = src & ~src_q;
    clr_v = take ? (8'h01 << vec) : 8'h00;
  end
`else
  // Level mode: pend simply tracks the registered source lines
  always_comb begin
    set_v = src_q;
    clr_v = ~src_q;
  end
`endif

  // A set in the same cycle as a clear leaves the bit set
  always_comb begin
    pend_next = set_v | (pend & ~clr_v);
  end

  // Single register stage on the raw inputs; all detection uses these copies
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q  <= 8'h00;
      iack_q <= 1'b0;
    end else begin
      src_q  <= src;
      iack_q <= iack;
    end
  end

  // Mask and pending registers; masking a source never clears its pend bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= RESET_MASK;
      pend <= 8'h00;
    end else begin
      if (mask_we) mask <= mask_wdata;
      pend <= pend_next;
    end
  end

  // Request handshake FSM with registered irq, vec and in_service
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      vec        <= 3'd0;
      irq        <= 1'b0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state <= REQ;
            vec   <= win_idx;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (iack_rise) begin
            state      <= SERV;
            irq        <= 1'b0;
            in_service <= 1'b1;
          end else if (!eligible[vec]) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERV: begin
          if (iack_fall) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed scenarios plus randomized traffic for irq_ctl, checked
// against a behavioural model of the controller. Follows IRQ_EDGE_EN like the design.

module tb_irq_ctl;

  localparam logic [7:0] RST_MASK = 8'h00;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic       iack;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pend;
  logic       irq;
  logic [2:0] vec;
  logic       in_service;

  int n_checks;
  int n_fail;

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = being serviced
  bit [7:0] m_srcq;
  bit [7:0] m_pend;
  bit [7:0] m_mask;
  bit       m_iackq;
  int       m_phase;
  int       m_vec;

  irq_ctl #(.RESET_MASK(RST_MASK)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .iack       (iack),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pend       (pend),
    .irq        (irq),
    .vec        (vec),
    .in_service (in_service)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock: model the edge from the current inputs, then sample 1ns later
  task automatic tick();
    bit [7:0] elig;
    bit [7:0] np;
    bit [7:0] nm;
    int       nphase;
    int       nvec;
    int       cleared;
    if (!rst) begin
      np = 8'h00; nm = RST_MASK; nphase = 0; nvec = 0;
    end else begin
      elig    = m_pend & m_mask;
      nphase  = m_phase;
      nvec    = m_vec;
      cleared = -1;
      if (m_phase == 0) begin
        if (lowest(elig) >= 0) begin
          nphase = 1;
          nvec   = lowest(elig);
        end
      end else if (m_phase == 1) begin
        if (iack && !m_iackq) begin
          nphase  = 2;
          cleared = m_vec;
        end else if (!elig[m_vec]) begin
          nphase = 0;
        end
      end else begin
        if (!iack && m_iackq) nphase = 0;
      end
`ifdef IRQ_EDGE_EN
      np = m_pend;
      for (int i = 0; i < 8; i++) begin
        if (i == cleared) np[i] = 1'b0;
        if (src[i] && !m_srcq[i]) np[i] = 1'b1;
      end
`else
      np = m_srcq;
`endif
      nm = mask_we ? mask_wdata : m_mask;
    end
    @(posedge clk);
    #1;
    m_pend  = np;
    m_mask  = nm;
    m_phase = nphase;
    m_vec   = nvec;
    m_srcq  = rst ? src : 8'h00;
    m_iackq = rst ? iack : 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; src = 8'h00; iack = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic write_mask(input bit [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; src = 8'hFF; iack = 1'b1; mask_we = 1'b1; mask_wdata = 8'h5A;
    tick();
    tick();
    n_checks++;
    if ({mask, pend, irq, vec, in_service} !== {RST_MASK, 8'h00, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: mask=%h pend=%h irq=%b vec=%0d insvc=%b, required mask=%h pend=00 irq=0 vec=0 insvc=0",
               mask, pend, irq, vec, in_service, RST_MASK);
    end
    mask_we = 1'b0; src = 8'h00; iack = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single_request();
    do_reset();
    write_mask(8'hFF);
    src = 8'h08;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
    n_checks++;
    if (pend !== 8'h08) begin
      n_fail++;
      $display("[TB] FAIL single_pend: pend=%h, required 08", pend);
    end
`endif
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL single_irq: irq=%b vec=%0d, required irq=1 vec=3", irq, vec);
    end
    iack = 1'b1; src = 8'h00;
    tick();
    n_checks++;
    if (irq !== 1'b0 || in_service !== 1'b1 || vec !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL single_take: irq=%b insvc=%b vec=%0d, required irq=0 insvc=1 vec=3", irq, in_service, vec);
    end
`ifdef IRQ_EDGE_EN
    n_checks++;
    if (pend !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL single_clear: pend=%h, required 00", pend);
    end
`endif
    iack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0 || in_service !== 1'b0 || pend !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL single_return: irq=%b insvc=%b pend=%h, required irq=0 insvc=0 pend=00", irq, in_service, pend);
    end
  endtask

  task automatic test_priority();
    do_reset();
    write_mask(8'hFF);
    src = 8'h24;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
`endif
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL prio_first: irq=%b vec=%0d, required irq=1 vec=2", irq, vec);
    end
    iack = 1'b1;
`ifndef IRQ_EDGE_EN
    src = 8'h20;
`endif
    tick();
    n_checks++;
    if (irq !== 1'b0 || in_service !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL prio_serv: irq=%b insvc=%b, required irq=0 insvc=1", irq, in_service);
    end
    iack = 1'b0;
    tick();
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd5) begin
      n_fail++;
      $display("[TB] FAIL prio_second: irq=%b vec=%0d, required irq=1 vec=5", irq, vec);
    end
    // A higher-priority source arriving now must wait for the next pass
`ifdef IRQ_EDGE_EN
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
`else
    src = 8'h21;
    tick();
    tick();
`endif
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd5) begin
      n_fail++;
      $display("[TB] FAIL prio_hold: irq=%b vec=%0d, required irq=1 vec=5", irq, vec);
    end
    iack = 1'b1;
`ifndef IRQ_EDGE_EN
    src = 8'h01;
`endif
    tick();
    iack = 1'b0;
    tick();
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL prio_late: irq=%b vec=%0d, required irq=1 vec=0", irq, vec);
    end
  endtask

  task automatic test_mask_enable();
    do_reset();
    write_mask(8'h00);
    src = 8'h02;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
`endif
    tick();
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0 || pend !== 8'h02) begin
      n_fail++;
      $display("[TB] FAIL masked_hold: irq=%b pend=%h, required irq=0 pend=02", irq, pend);
    end
    write_mask(8'h02);
    tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd1 || mask !== 8'h02) begin
      n_fail++;
      $display("[TB] FAIL unmask_irq: irq=%b vec=%0d mask=%h, required irq=1 vec=1 mask=02", irq, vec, mask);
    end
  endtask

  task automatic test_mask_drop();
    do_reset();
    write_mask(8'hFF);
    src = 8'h10;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
`endif
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    n_checks++;
    if (irq !== 1'b1 || vec !== 3'd4) begin
      n_fail++;
      $display("[TB] FAIL drop_req: irq=%b vec=%0d, required irq=1 vec=4", irq, vec);
    end
    write_mask(8'hEF);
    tick();
    n_checks++;
    if (irq !== 1'b0 || in_service !== 1'b0 || pend[4] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_withdraw: irq=%b insvc=%b pend=%h, required irq=0 insvc=0 pend[4]=1", irq, in_service, pend);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_stay_idle: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_reset_in_serv();
    do_reset();
    write_mask(8'hFF);
    src = 8'h01;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
`endif
    for (int k = 0; k < 8 && irq !== 1'b1; k++) tick();
    iack = 1'b1; src = 8'h81;
    tick();
`ifdef IRQ_EDGE_EN
    src = 8'h00;
`endif
    tick();
    n_checks++;
    if (in_service !== 1'b1 || pend !== 8'h81) begin
      n_fail++;
      $display("[TB] FAIL serv_setup: insvc=%b pend=%h, required insvc=1 pend=81", in_service, pend);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({irq, in_service, pend, mask, vec} !== {1'b0, 1'b0, 8'h00, RST_MASK, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL serv_abort: irq=%b insvc=%b pend=%h mask=%h vec=%0d, required irq=0 insvc=0 pend=00 mask=%h vec=0",
               irq, in_service, pend, mask, vec, RST_MASK);
    end
    rst = 1'b1; iack = 1'b0; src = 8'h00;
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    do_reset();
    for (int c = 0; c < 600; c++) begin
`ifdef IRQ_EDGE_EN
      src = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
`else
      if ($urandom_range(0, 2) == 0) src = 8'($urandom & $urandom);
`endif
      if ($urandom_range(0, 3) == 0) iack = ~iack;
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 8'($urandom);
      rst        = ($urandom_range(0, 59) != 0);
      tick();
      exp_v = {m_mask, m_pend, (m_phase == 1), 3'(m_vec), (m_phase == 2)};
      n_checks++;
      if ({mask, pend, irq, vec, in_service} !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: mask=%h pend=%h irq=%b vec=%0d insvc=%b, required mask=%h pend=%h irq=%b vec=%0d insvc=%b",
                 c, mask, pend, irq, vec, in_service,
                 exp_v[20:13], exp_v[12:5], exp_v[4], exp_v[3:1], exp_v[0]);
      end
    end
    rst = 1'b1; mask_we = 1'b0;
  endtask

  // Scenario sequence and summary
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; src = 8'h00; iack = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
    m_srcq = 8'h00; m_pend = 8'h00; m_mask = RST_MASK; m_iackq = 1'b0;
    m_phase = 0; m_vec = 0;
    test_reset();
    test_single_request();
    test_priority();
    test_mask_enable();
    test_mask_drop();
    test_reset_in_serv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
